// File: rtl/key_conditioner.sv
// Raw DE2-115 KEY front end: 2-FF sync, per-key debounce, chord merge, and a
// single-cycle active-low event on btn per physical press.
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COMBO_CYCLES    = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] btn,
    output logic              btn_valid,
    output logic [N_KEYS-1:0] key_stable,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam int WIN_MAX = (COMBO_CYCLES > DEBOUNCE_CYCLES + 2) ? COMBO_CYCLES
                                                                  : DEBOUNCE_CYCLES + 2;
    localparam int WW = $clog2(WIN_MAX + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_REL  = WW'(DEBOUNCE_CYCLES + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(COMBO_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        COLLECT  = 2'd2,
        EMIT     = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [CW-1:0]     cnt [N_KEYS];
    logic              cnt_idle;
    logic              quiet;

    state_t            state_q;
    logic [N_KEYS-1:0] chord;
    logic [WW-1:0]     win_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '1;
            sync2      <= '1;
            key_stable <= '1;
            for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2[i] == key_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    key_stable[i] <= sync2[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Quiet means nothing pressed, nothing in flight through sync, nothing mid-debounce.
    always_comb begin
        cnt_idle = 1'b1;
        for (int i = 0; i < N_KEYS; i++) begin
            if (cnt[i] != '0) cnt_idle = 1'b0;
        end
    end

    assign quiet = (&key_stable) & (&sync2) & cnt_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_REL;
            chord   <= '0;
            win_cnt <= '0;
        end else begin
            case (state_q)
                WAIT_REL: begin
                    if (!quiet) begin
                        win_cnt <= '0;
                    end else if (win_cnt == WIN_REL) begin
                        state_q <= IDLE;
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                    end
                end
                IDLE: begin
                    if (key_stable != '1) begin
                        state_q <= COLLECT;
                        chord   <= ~key_stable;
                        win_cnt <= '0;
                    end
                end
                COLLECT: begin
                    // Released keys stay in the chord; new ones are OR-ed in.
                    chord <= chord | ~key_stable;
                    if (key_stable == '1 || win_cnt == WIN_LAST) begin
                        state_q <= EMIT;
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                    end
                end
                EMIT: begin
                    state_q <= WAIT_REL;
                    win_cnt <= '0;
                end
                default: begin
                    state_q <= WAIT_REL;
                    win_cnt <= '0;
                end
            endcase
        end
    end

    assign btn       = (state_q == EMIT) ? ~chord : '1;
    assign btn_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, COMBO_CYCLES=8.
// Each table row holds its inputs for n cycles and checks all outputs every cycle.
module tb_key_conditioner;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_COLL = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] btn;
    logic       btn_valid;
    logic [3:0] key_stable;
    logic       busy;
    logic [1:0] fsm_state;

    int n_vec = 0;
    int n_err = 0;
    int row   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] key_n;
        int         n;
        logic [3:0] btn;
        logic       valid;
        logic [3:0] stable;
        logic       busy;
        logic [1:0] st;
    } seg_t;

    seg_t tbl[$];
    int   bounce_at;

    key_conditioner #(
        .N_KEYS(4),
        .DEBOUNCE_CYCLES(4),
        .COMBO_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .btn(btn),
        .btn_valid(btn_valid),
        .key_stable(key_stable),
        .busy(busy),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s row %0d t=%0t: got %b, want %b", name, row, $time, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] k, input int n, input logic [3:0] b,
                       input logic v, input logic [3:0] s, input logic bz, input logic [1:0] st);
        tbl.push_back('{r, k, n, b, v, s, bz, st});
    endtask

    task automatic apply_seg(input seg_t sg);
        for (int c = 0; c < sg.n; c++) begin
            @(negedge clk);
            rst   = sg.rst;
            key_n = sg.key_n;
            @(posedge clk);
            #1;
            check("btn", btn, sg.btn);
            check("btn_valid", {3'b0, btn_valid}, {3'b0, sg.valid});
            check("key_stable", key_stable, sg.stable);
            check("busy", {3'b0, busy}, {3'b0, sg.busy});
            check("state", {2'b0, fsm_state}, {2'b0, sg.st});
        end
    endtask

    initial begin
        // Reset, then 6 quiet edges to reach IDLE.
        add(1, 4'hF, 2, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'hF, 3, 4'hF, 0, 4'hF, 0, S_IDLE);
        // Clean single press of key 0: stable edge 6, COLLECT edge 7, EMIT edge 15.
        add(0, 4'hE, 5, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'hE, 1, 4'hF, 0, 4'hE, 0, S_IDLE);
        add(0, 4'hE, 8, 4'hF, 0, 4'hE, 1, S_COLL);
        add(0, 4'hE, 1, 4'hE, 1, 4'hE, 1, S_EMIT);
        add(0, 4'hE, 30, 4'hF, 0, 4'hE, 1, S_WAIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'hE, 1, S_WAIT);
        add(0, 4'hF, 6, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        // Chord: key 2 then key 1 three cycles later, one event with both.
        add(0, 4'hB, 3, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'h9, 2, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'h9, 1, 4'hF, 0, 4'hB, 0, S_IDLE);
        add(0, 4'h9, 2, 4'hF, 0, 4'hB, 1, S_COLL);
        add(0, 4'h9, 6, 4'hF, 0, 4'h9, 1, S_COLL);
        add(0, 4'h9, 1, 4'h9, 1, 4'h9, 1, S_EMIT);
        add(0, 4'h9, 10, 4'hF, 0, 4'h9, 1, S_WAIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'h9, 1, S_WAIT);
        add(0, 4'hF, 6, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        bounce_at = tbl.size();
        // Early release: key 1 released once stable, EMIT on edge 13 not 15.
        add(0, 4'hD, 5, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'hD, 1, 4'hF, 0, 4'hD, 0, S_IDLE);
        add(0, 4'hF, 5, 4'hF, 0, 4'hD, 1, S_COLL);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 1, S_COLL);
        add(0, 4'hF, 1, 4'hD, 1, 4'hF, 1, S_EMIT);
        add(0, 4'hF, 6, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        // Key 3 held through a 2-cycle reset and for 100 cycles: no event.
        add(1, 4'h7, 2, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'h7, 5, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'h7, 95, 4'hF, 0, 4'h7, 1, S_WAIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'h7, 1, S_WAIT);
        add(0, 4'hF, 6, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        // Fresh press of the same key emits normally, then release right after.
        add(0, 4'h7, 5, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'h7, 1, 4'hF, 0, 4'h7, 0, S_IDLE);
        add(0, 4'h7, 8, 4'hF, 0, 4'h7, 1, S_COLL);
        add(0, 4'h7, 1, 4'h7, 1, 4'h7, 1, S_EMIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'h7, 1, S_WAIT);
        add(0, 4'hF, 6, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        // Reset one cycle into COLLECT: chord discarded, never emitted.
        add(0, 4'hE, 5, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'hE, 1, 4'hF, 0, 4'hE, 0, S_IDLE);
        add(0, 4'hE, 1, 4'hF, 0, 4'hE, 1, S_COLL);
        add(1, 4'hF, 1, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 5, 4'hF, 0, 4'hF, 1, S_WAIT);
        add(0, 4'hF, 1, 4'hF, 0, 4'hF, 0, S_IDLE);
        add(0, 4'hF, 20, 4'hF, 0, 4'hF, 0, S_IDLE);

        for (int r = 0; r < tbl.size(); r++) begin
            if (r == bounce_at) begin
                // Bounce on key 0: 3-cycle low/high pulses never pass the debouncer.
                for (int p = 0; p < 14; p++) begin
                    apply_seg('{1'b0, (p % 2 == 0) ? 4'hE : 4'hF, 3,
                                4'hF, 1'b0, 4'hF, 1'b0, S_IDLE});
                end
            end
            row = r;
            apply_seg(tbl[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input stage that sits directly upstream of the safe FSM.
- Takes the raw active-low DE2-115 KEY inputs and runs them through a 2-FF synchronizer and a per-key debouncer.
- Merges near-simultaneous presses into one chord, then emits each chord as a single-cycle active-low code on `btn`. Between events `btn` rests at all-ones, the "no key" value.
- Result: one physical press produces exactly one FSM event, never repeated while held and never triggered by bounce.

Parameters:
- N_KEYS, 4, number of keys.
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized level must hold before it is accepted (10 ms at 100 MHz). Must be ≥1.
- COMBO_CYCLES, 2_000_000, chord collection window after the first accepted press (20 ms). Must be ≥1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- key_n  in  N_KEYS  raw keys, asynchronous, active-low (0 = pressed).
- btn  out  N_KEYS  active-low chord code. Driven with the code during the EMIT cycle only, all-ones otherwise.
- btn_valid  out  1  high exactly in the EMIT cycle.
- key_stable  out  N_KEYS  debounced level per key, active-low.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- **Reset.** One clock, synchronous active-high reset. `rst` sampled high on an edge sets:
  - sync regs = all-ones, key_stable = all-ones, debounce counters = 0;
  - chord = 0, win_cnt = 0, state = WAIT_REL.
  - Resulting outputs: btn = all-ones, btn_valid = 0, busy = 1.
  - Reset mid-operation discards any pending chord; no emit occurs.
- **Synchronizer.** Two flops per bit; sync2 is the synchronized level.
- **Debounce, per bit i:**
  - If sync2[i] == key_stable[i]: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: key_stable[i] <= sync2[i] and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
  - For a clean level change first sampled on edge 1, key_stable changes on edge DEBOUNCE_CYCLES+2.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches key_stable.
- **State machine** (state register; outputs decoded from registers only):
  - **WAIT_REL**
    - Condition "quiet" = key_stable all-ones AND sync2 all-ones AND every cnt_i == 0.
    - Quiet: win_cnt increments. Not quiet: win_cnt <= 0.
    - When quiet holds and win_cnt == DEBOUNCE_CYCLES+1 → IDLE, win_cnt <= 0.
    - Consequence: a key held through reset, or held after an emit, produces no event until it is fully released.
  - **IDLE**
    - If key_stable != all-ones → COLLECT, chord <= ~key_stable, win_cnt <= 0.
  - **COLLECT**
    - Every edge: chord <= chord | ~key_stable.
    - If key_stable == all-ones (early release) or win_cnt == COMBO_CYCLES-1 → EMIT.
    - Otherwise win_cnt <= win_cnt + 1.
  - **EMIT**
    - btn = ~chord, btn_valid = 1, for exactly one cycle.
    - Next state is WAIT_REL, win_cnt <= 0.
- **Latency.** For a clean single-key press first sampled on edge 1 and held:
  - key_stable falls on edge D+2;
  - COLLECT is entered on edge D+3;
  - EMIT is entered on edge D+3+C, so btn_valid is high in the cycle after that edge.
  - Here D = DEBOUNCE_CYCLES and C = COMBO_CYCLES.
- **Chord content.** Keys released inside the window stay set in chord (OR accumulation). A chord is never empty at EMIT.
- **Widths.** win_cnt width = clog2(max(COMBO_CYCLES, DEBOUNCE_CYCLES+2)+1). cnt_i width = clog2(DEBOUNCE_CYCLES+1). Counters never wrap.
- **Output guarantees.**
  - btn never takes any value other than all-ones or a chord code.
  - btn_valid pulses are separated by at least DEBOUNCE_CYCLES+2 cycles of WAIT_REL.

Test Plan:
- Use D=4, C=8 throughout.
- **Clean single press.** After reset, wait for IDLE; drive key_n=1110 and hold. Require:
  - btn_valid high for exactly one cycle, in the cycle after edge 15 counted from the first sampling edge;
  - btn=1110 in that cycle and 1111 in all others;
  - no second pulse while the key is held.
- **Chord.** From IDLE, key_n=1011, then 3 cycles later key_n=1001, hold. Require a single pulse with btn=1001.
- **Bounce rejection.** From IDLE, toggle key_n[0] low/high with 3-cycle pulses for 40 cycles. Require:
  - key_stable stays 1111;
  - btn_valid never asserts;
  - busy stays 0.
- **Early release.** From IDLE, key_n=1101 held until key_stable falls, then released. Require:
  - EMIT occurs on the edge after key_stable returns to 1111, before the 8-cycle window expires;
  - btn=1101.
- **Key held through reset.** Hold key_n=0111 while pulsing rst for 2 cycles, keep it held for 100 cycles. Require:
  - no btn_valid while held;
  - after release, the FSM reaches IDLE after 6 or more quiet edges;
  - a fresh press of the same key emits 0111.
- **Reset mid-COLLECT.** Assert rst one cycle in COLLECT. Require:
  - btn=1111, btn_valid=0, state WAIT_REL after the reset edge;
  - no emit of the discarded chord.
